hazard_fwd_unit: RTL

- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline_cpu.
- Replaces the single-source EXE-only forwarding select with a 3-source forwarding network (EXE/MEM, MEM/WB, register file).
- Adds load-use stall detection with a configurable stall length and taken-branch flush with a configurable penalty.
- Drives the PC enable, the IF_ID enable/flush, the ID_EXE flush and the ALU operand mux selects.

---
 rtl/hazard_fwd_unit_if.sv | 51 +++++
 rtl/hazard_fwd_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - pipeline-side bundle for hazard_fwd_unit
// Optional perf-counter members are present when HAZARD_PERF_CNT_EN is defined.
interface hazard_fwd_unit_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] exe_rs;
  logic [REG_AW-1:0] exe_rt;
  logic [REG_AW-1:0] exe_num_write;
  logic              exe_reg_write;
  logic              exe_mem_read;
  logic [REG_AW-1:0] mem_num_write;
  logic              mem_reg_write;
  logic [REG_AW-1:0] wb_num_write;
  logic              wb_reg_write;
  logic              branch_taken;
  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_exe_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_cycles;
`endif

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, exe_rs, exe_rt, exe_num_write,
           exe_reg_write, exe_mem_read, mem_num_write, mem_reg_write,
           wb_num_write, wb_reg_write, branch_taken,
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cycles, flush_cycles,
`endif
    input  pc_en, if_id_en, if_id_flush, id_exe_flush, fwd_a, fwd_b, busy
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, exe_rs, exe_rt, exe_num_write,
           exe_reg_write, exe_mem_read, mem_num_write, mem_reg_write,
           wb_num_write, wb_reg_write, branch_taken,
`ifdef HAZARD_PERF_CNT_EN
    output stall_cycles, flush_cycles,
`endif
    output pc_en, if_id_en, if_id_flush, id_exe_flush, fwd_a, fwd_b, busy
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - 3-source forwarding, load-use stall and branch flush control
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush cycle counters.
module hazard_fwd_unit #(
  parameter int REG_AW         = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 4
) (
  input  logic             clock,
  input  logic             reset,
  hazard_fwd_unit_if.slave hz
);
  typedef enum logic [1:0] {RUN, LSTALL, BFLUSH} state_t;

  // The RUN cycle that detects the event is the first bubble, hence the -2 reloads.
  localparam logic [CNT_W-1:0] LS_LOAD = CNT_W'(LOAD_STALL_CYC > 1 ? LOAD_STALL_CYC - 2 : 0);
  localparam logic [CNT_W-1:0] BF_LOAD = CNT_W'(BRANCH_PENALTY > 1 ? BRANCH_PENALTY - 2 : 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             busy_q;
  logic             lu;
  logic             br_flush;
  logic             ld_stall;

  always_comb begin
    lu = hz.exe_mem_read && (hz.exe_num_write != '0) &&
         ((hz.id_use_rs && (hz.id_rs == hz.exe_num_write)) ||
          (hz.id_use_rt && (hz.id_rt == hz.exe_num_write)));
  end

  always_comb begin
    br_flush = 1'b0;
    ld_stall = 1'b0;
    case (state)
      BFLUSH:  br_flush = 1'b1;
      LSTALL:  if (hz.branch_taken) br_flush = 1'b1; else ld_stall = 1'b1;
      default: if (hz.branch_taken) br_flush = 1'b1; else ld_stall = lu;
    endcase
  end

  always_comb begin
    hz.pc_en        = 1'b1;
    hz.if_id_en     = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_exe_flush = 1'b0;
    hz.fwd_a        = 2'b00;
    hz.fwd_b        = 2'b00;
    if (!reset) begin
      hz.pc_en        = 1'b0;
      hz.if_id_en     = 1'b0;
      hz.if_id_flush  = 1'b1;
      hz.id_exe_flush = 1'b1;
    end else begin
      if (br_flush) begin
        hz.if_id_flush  = 1'b1;
        hz.id_exe_flush = 1'b1;
      end else if (ld_stall) begin
        hz.pc_en        = 1'b0;
        hz.if_id_en     = 1'b0;
        hz.id_exe_flush = 1'b1;
      end
      // MEM result is younger than WB, so it wins; $0 is hardwired and never forwarded.
      if (hz.mem_reg_write && hz.mem_num_write == hz.exe_rs && hz.exe_rs != '0)
        hz.fwd_a = 2'b01;
      else if (hz.wb_reg_write && hz.wb_num_write == hz.exe_rs && hz.exe_rs != '0)
        hz.fwd_a = 2'b10;
      if (hz.mem_reg_write && hz.mem_num_write == hz.exe_rt && hz.exe_rt != '0)
        hz.fwd_b = 2'b01;
      else if (hz.wb_reg_write && hz.wb_num_write == hz.exe_rt && hz.exe_rt != '0)
        hz.fwd_b = 2'b10;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (hz.branch_taken) begin
          if (BRANCH_PENALTY > 1) begin
            state_nxt = BFLUSH;
            cnt_nxt   = BF_LOAD;
          end
        end else if (lu && LOAD_STALL_CYC > 1) begin
          state_nxt = LSTALL;
          cnt_nxt   = LS_LOAD;
        end
      end
      LSTALL: begin
        if (hz.branch_taken) begin
          if (BRANCH_PENALTY > 1) begin
            state_nxt = BFLUSH;
            cnt_nxt   = BF_LOAD;
          end else begin
            state_nxt = RUN;
          end
        end else if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      BFLUSH: begin
        if (hz.branch_taken) cnt_nxt = BF_LOAD;
        else if (cnt == '0)  state_nxt = RUN;
        else                 cnt_nxt = cnt - 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= RUN;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= (state_nxt != RUN);
    end
  end

  assign hz.busy = busy_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!hz.pc_en && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      if (br_flush && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_cycles = flush_q;
`endif
endmodule
